// File: rtl/update_knn13_udiv_seq_if.sv
// Handshake bundle for the update_knn13 sequential divider:
// operand channel (valid/ready) and result channel (valid/ready).
interface update_knn13_udiv_seq_if #(
   parameter int unsigned DIVIDEND_WIDTH = 32,
   parameter int unsigned DIVISOR_WIDTH  = 15,
   parameter int unsigned QUOT_WIDTH     = 17
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DIVIDEND_WIDTH-1:0] din0;
   logic [DIVISOR_WIDTH-1:0]  din1;
   logic                      out_valid;
   logic                      out_ready;
   logic [QUOT_WIDTH-1:0]     quot;
   logic [DIVISOR_WIDTH-1:0]  rem;
   logic                      ovf;
   logic                      dbz;

   modport master (
      output in_valid, din0, din1, out_ready,
      input  in_ready, out_valid, quot, rem, ovf, dbz
   );

   modport slave (
      input  in_valid, din0, din1, out_ready,
      output in_ready, out_valid, quot, rem, ovf, dbz
   );
endinterface

// File: rtl/update_knn13_udiv_seq.sv
// Iterative unsigned restoring divider, one quotient bit per enabled cycle.
// Recovers the 17-bit factor from a 32-bit product and a 15-bit divisor.
module update_knn13_udiv_seq #(
   parameter int unsigned DIVIDEND_WIDTH = 32,
   parameter int unsigned DIVISOR_WIDTH  = 15,
   parameter int unsigned QUOT_WIDTH     = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   update_knn13_udiv_seq_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DIVIDEND_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                    state;
   logic [CNT_W-1:0]          count;
   logic [DIVIDEND_WIDTH-1:0] dq;
   logic [DIVISOR_WIDTH-1:0]  divisor;
   logic [DIVISOR_WIDTH-1:0]  part;
   logic [QUOT_WIDTH-1:0]     quot_r;
   logic [DIVISOR_WIDTH-1:0]  rem_r;
   logic                      ovf_r;
   logic                      dbz_r;
   logic                      out_valid_r;

   logic [DIVISOR_WIDTH:0]    trial;
   logic [DIVISOR_WIDTH:0]    diff;
   logic                      fits;
   logic [DIVISOR_WIDTH-1:0]  part_next;
   logic [DIVIDEND_WIDTH-1:0] dq_next;
   logic                      accept;

   // dq shifts the dividend out at the top while quotient bits enter at the
   // bottom, so after the last step it holds the full quotient.
   always_comb begin
      trial     = {part, dq[DIVIDEND_WIDTH-1]};
      diff      = trial - {1'b0, divisor};
      fits      = (trial >= {1'b0, divisor});
      part_next = fits ? diff[DIVISOR_WIDTH-1:0] : trial[DIVISOR_WIDTH-1:0];
      dq_next   = {dq[DIVIDEND_WIDTH-2:0], fits};
   end

   assign bus.in_ready  = (state == IDLE) & ce & reset;
   assign bus.out_valid = out_valid_r;
   assign bus.quot      = quot_r;
   assign bus.rem       = rem_r;
   assign bus.ovf       = ovf_r;
   assign bus.dbz       = dbz_r;
   assign accept        = bus.in_valid & bus.in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         dq          <= '0;
         divisor     <= '0;
         part        <= '0;
         quot_r      <= '0;
         rem_r       <= '0;
         ovf_r       <= 1'b0;
         dbz_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (ce) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dq      <= bus.din0;
                  divisor <= bus.din1;
                  part    <= '0;
                  count   <= CNT_W'(DIVIDEND_WIDTH);
                  if (bus.din1 == '0) begin
                     quot_r      <= '1;
                     rem_r       <= bus.din0[DIVISOR_WIDTH-1:0];
                     ovf_r       <= 1'b0;
                     dbz_r       <= 1'b1;
                     out_valid_r <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               dq    <= dq_next;
               part  <= part_next;
               count <= count - 1'b1;
               if (count == CNT_W'(1)) begin
                  quot_r      <= dq_next[QUOT_WIDTH-1:0];
                  rem_r       <= part_next;
                  ovf_r       <= |dq_next[DIVIDEND_WIDTH-1:QUOT_WIDTH];
                  dbz_r       <= 1'b0;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule
